pipeline_hazard_controller: RTL and testbench

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

---
 rtl/pipeline_hazard_controller.sv | 127 ++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: memory-stall freeze, branch flush and load-use bubble.
// Optional performance counters are built only when PERF_COUNTERS_EN is defined.
module pipeline_hazard_controller #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [4:0]           id_rs,
  input  logic [4:0]           id_rt,
  input  logic                 id_uses_rt,
  input  logic                 ex_is_load,
  input  logic [4:0]           ex_rt,
  input  logic                 branch_taken,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 if_id_write,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 back_write,
  output logic                 mem_error,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_count
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                load_use;

  // rt only matters when the ID instruction actually reads it; r0 never hazards
  assign load_use = ex_is_load && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  assign mem_error = (state_q == ST_ERROR);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    back_write  = 1'b1;
    // While reset is held the free-running defaults are presented regardless of inputs
    if (reset_n) begin
      case (state_q)
        ST_RUN: begin
          if (mem_req && !mem_ready) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            back_write  = 1'b0;
            state_d     = ST_MEM_WAIT;
            wait_d      = '0;
          end else if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          back_write  = 1'b0;
          if (mem_ready) begin
            back_write = 1'b1;
            state_d    = ST_RUN;
          end else if (wait_q == WAIT_LAST) begin
            state_d = ST_ERROR;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        ST_ERROR: begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          back_write  = 1'b0;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

`ifdef PERF_COUNTERS_EN
  logic [CNT_WIDTH-1:0] stall_q, flush_q;

  // Saturating counters; if_id_flush is asserted only on branch-flush cycles
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_write && (stall_q != '1)) stall_q <= stall_q + CNT_WIDTH'(1);
      if (if_id_flush && (flush_q != '1)) flush_q <= flush_q + CNT_WIDTH'(1);
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller (MEM_TIMEOUT=8, CNT_WIDTH=4).
module tb_pipeline_hazard_controller;

  localparam int unsigned CW = 4;
`ifdef PERF_COUNTERS_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc_write, if_id_write, if_id_flush, id_ex_flush, back_write}
  localparam logic [4:0] NONE    = 5'b11001;
  localparam logic [4:0] STALL   = 5'b00011;
  localparam logic [4:0] FLUSH   = 5'b11111;
  localparam logic [4:0] FROZEN  = 5'b00000;
  localparam logic [4:0] MEMDONE = 5'b00001;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [4:0]    id_rs = '0, id_rt = '0, ex_rt = '0;
  logic          id_uses_rt = 1'b0, ex_is_load = 1'b0, branch_taken = 1'b0;
  logic          mem_req = 1'b0, mem_ready = 1'b0;
  logic          pc_write, if_id_write, if_id_flush, id_ex_flush, back_write, mem_error;
  logic [CW-1:0] stall_cycles, flush_count;
  logic [4:0]    outs;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0] rs, rt;
    logic       uses_rt, is_load;
    logic [4:0] ert;
    logic       br, req, rdy;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[13];

  pipeline_hazard_controller #(.MEM_TIMEOUT(8), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset_n(reset_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_is_load(ex_is_load), .ex_rt(ex_rt), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .back_write(back_write), .mem_error(mem_error),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  assign outs = {pc_write, if_id_write, if_id_flush, id_ex_flush, back_write};

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic u,
                              input logic ld, input logic [4:0] ert, input logic br,
                              input logic req, input logic rdy, input logic [4:0] exp);
    vec_t v;
    v.rs = rs; v.rt = rt; v.uses_rt = u; v.is_load = ld; v.ert = ert;
    v.br = br; v.req = req; v.rdy = rdy; v.exp = exp;
    return v;
  endfunction

  function automatic int sat(input int v);
    if (!PERF) return 0;
    return (v > 15) ? 15 : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.uses_rt; ex_is_load = v.is_load;
    ex_rt = v.ert; branch_taken = v.br; mem_req = v.req; mem_ready = v.rdy;
  endtask

  task automatic idle();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, NONE));
  endtask

  task automatic load_use_in();
    apply(mk(5, 0, 0, 1, 5, 0, 0, 0, STALL));
  endtask

  // Check combinational outputs just after the falling edge, then advance one cycle
  task automatic step(input string name, input logic [4:0] exp);
    #1;
    chk(name, 32'(outs), 32'(exp));
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    idle();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic chk_cnt(input string name, input int st, input int fl);
    #1;
    chk({name, "_stall"}, 32'(stall_cycles), 32'(sat(st)));
    chk({name, "_flush"}, 32'(flush_count), 32'(sat(fl)));
  endtask

  initial begin
    int stall_m, flush_m;
    vecs[0]  = mk(0,  0,  0, 0, 0,  0, 0, 0, NONE);
    vecs[1]  = mk(5,  0,  0, 1, 5,  0, 0, 0, STALL);
    vecs[2]  = mk(0,  0,  0, 1, 0,  0, 0, 0, NONE);
    vecs[3]  = mk(2,  7,  1, 1, 7,  0, 0, 0, STALL);
    vecs[4]  = mk(3,  7,  0, 1, 7,  0, 0, 0, NONE);
    vecs[5]  = mk(5,  0,  0, 0, 5,  0, 0, 0, NONE);
    vecs[6]  = mk(1,  2,  1, 0, 9,  1, 0, 0, FLUSH);
    vecs[7]  = mk(5,  5,  1, 1, 5,  1, 0, 0, FLUSH);
    vecs[8]  = mk(4,  0,  0, 1, 4,  0, 1, 1, STALL);
    vecs[9]  = mk(0,  0,  0, 0, 0,  0, 0, 1, NONE);
    vecs[10] = mk(0,  0,  0, 0, 0,  1, 1, 1, FLUSH);
    vecs[11] = mk(30, 31, 1, 1, 31, 0, 0, 0, STALL);
    vecs[12] = mk(6,  0,  1, 1, 0,  0, 0, 0, NONE);

    // Reset state, and outputs forced to RUN defaults even with a hazard present
    #1;
    chk("rst_outs", 32'(outs), 32'(NONE));
    chk("rst_err", 32'(mem_error), 32'd0);
    chk_cnt("rst", 0, 0);
    load_use_in();
    #1;
    chk("rst_hazard_outs", 32'(outs), 32'(NONE));
    idle();
    @(negedge clock);
    reset_n = 1'b1;

    // Table of single-cycle RUN vectors
    stall_m = 0;
    flush_m = 0;
    foreach (vecs[i]) begin
      apply(vecs[i]);
      step($sformatf("vec%0d", i), vecs[i].exp);
      if (!vecs[i].exp[4]) stall_m++;
      if (vecs[i].exp[2]) flush_m++;
    end
    idle();
    chk_cnt("table", stall_m, flush_m);

    // Load-use bubble lasts one cycle
    do_reset();
    load_use_in();
    step("lu_bubble", STALL);
    idle();
    chk_cnt("lu_cnt", 1, 0);
    step("lu_after", NONE);

    // Branch beats load-use in the same cycle
    do_reset();
    apply(mk(5, 0, 0, 1, 5, 1, 0, 0, FLUSH));
    step("br_lu", FLUSH);
    idle();
    chk_cnt("br_lu_cnt", 0, 1);
    step("br_lu_after", NONE);

    // Memory stall with branch held through the wait
    do_reset();
    apply(mk(0, 0, 0, 0, 0, 0, 1, 0, FROZEN));
    step("mw_enter", FROZEN);
    branch_taken = 1'b1;
    step("mw_wait1", FROZEN);
    step("mw_wait2", FROZEN);
    mem_ready = 1'b1;
    step("mw_ready", MEMDONE);
    mem_req = 1'b0;
    mem_ready = 1'b0;
    step("mw_branch_after", FLUSH);
    idle();
    chk_cnt("mw_cnt", 4, 1);
    step("mw_run", NONE);

    // Timeout into ERROR, sticky until reset
    do_reset();
    apply(mk(0, 0, 0, 0, 0, 0, 1, 0, FROZEN));
    step("to_enter", FROZEN);
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("to_wait%0d_err", k), 32'(mem_error), 32'd0);
      step($sformatf("to_wait%0d", k), FROZEN);
    end
    mem_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("err%0d_flag", k), 32'(mem_error), 32'd1);
      step($sformatf("err%0d", k), FROZEN);
    end
    chk_cnt("err_cnt", 19, 0);
    #2;
    reset_n = 1'b0;
    load_use_in();
    #1;
    chk("err_rst_flag", 32'(mem_error), 32'd0);
    chk("err_rst_outs", 32'(outs), 32'(NONE));
    chk_cnt("err_rst", 0, 0);
    @(negedge clock);
    reset_n = 1'b1;
    idle();
    branch_taken = 1'b1;
    step("err_rst_run", FLUSH);
    idle();

    // Reset in the middle of a memory wait returns to RUN
    do_reset();
    apply(mk(0, 0, 0, 0, 0, 0, 1, 0, FROZEN));
    step("mwr_enter", FROZEN);
    idle();
    #3;
    reset_n = 1'b0;
    #1;
    chk("mwr_rst_outs", 32'(outs), 32'(NONE));
    @(negedge clock);
    reset_n = 1'b1;
    step("mwr_run", NONE);

    // Long held stall saturates the 4-bit counter
    do_reset();
    load_use_in();
    for (int k = 0; k < 19; k++) @(negedge clock);
    #1;
    chk("sat_outs", 32'(outs), 32'(STALL));
    chk_cnt("sat", 19, 0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
